rggen_access_arbiter: RTL

RGGEN_ACCESS_ARBITER -- requirements
Module: rggen_access_arbiter

---
 rtl/rggen_access_pkg.sv | 17 +
 rtl/rggen_rr_arbiter_2.sv | 26 ++
 rtl/rggen_access_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rggen_access_pkg.sv
// Shared types and constants for the two-requester register access arbiter.
package rggen_access_pkg;
    localparam int NUM_REQUESTERS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } access_state_e;

    typedef enum logic [1:0] {
        OKAY    = 2'b00,
        EXOKAY  = 2'b01,
        SLVERR  = 2'b10,
        TIMEOUT = 2'b11
    } access_status_e;
endpackage

// File: rtl/rggen_rr_arbiter_2.sv
// Two-way round-robin grant with a last-grant pointer; requester 0 wins the
// first tie after reset.
module rggen_rr_arbiter_2
    import rggen_access_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic                      update,
    output logic                      grant_valid,
    output logic                      grant_index
);
    logic last_grant;

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) grant_index = ~last_grant;
        else              grant_index = req[1];
    end

    // Pointer reset to 1 so the first tie goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      last_grant <= 1'b1;
        else if (update && grant_valid)  last_grant <= grant_index;
    end
endmodule

// File: rtl/rggen_access_arbiter.sv
// Arbitrates two register requesters onto one downstream access port with a
// bounded wait for ready and a one-cycle shared response.
module rggen_access_arbiter
    import rggen_access_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQUESTERS-1:0]                   i_req,
    input  logic [NUM_REQUESTERS-1:0]                   i_write,
    input  logic [NUM_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]    i_write_data,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]    i_write_mask,
    output logic [NUM_REQUESTERS-1:0]                   o_ack,
    output logic [DATA_WIDTH-1:0]                       o_read_data,
    output logic [1:0]                                  o_status,
    output logic                                        o_access_valid,
    output logic                                        o_access_write,
    output logic [ADDRESS_WIDTH-1:0]                    o_address,
    output logic [DATA_WIDTH-1:0]                       o_write_data,
    output logic [DATA_WIDTH-1:0]                       o_write_mask,
    input  logic                                        i_access_ready,
    input  logic [DATA_WIDTH-1:0]                       i_read_data,
    input  logic [1:0]                                  i_status
);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    access_state_e           state_q, state_d;
    logic                    armed_q;
    logic                    grant_q;
    logic                    write_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, mask_q, rdata_q;
    logic [1:0]              status_q;
    logic [15:0]             count_q;
    logic                    grant_valid, grant_index;
    logic                    start, timeout_hit;

    rggen_rr_arbiter_2 u_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (i_req),
        .update      (start),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    // armed_q holds off granting until the second edge after reset release.
    assign start       = (state_q == IDLE) && armed_q && grant_valid;
    assign timeout_hit = (state_q == ACCESS) && !i_access_ready && (count_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCESS;
            ACCESS:  if (i_access_ready || timeout_hit) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload is captured once at grant and held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (start) begin
            grant_q <= grant_index;
            write_q <= i_write[grant_index];
            addr_q  <= i_address[grant_index];
            wdata_q <= i_write_data[grant_index];
            mask_q  <= i_write_mask[grant_index];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      count_q <= '0;
        else if (start)                                  count_q <= '0;
        else if (state_q == ACCESS && !i_access_ready)   count_q <= count_q + 16'd1;
    end

    // Ready on the last allowed cycle takes precedence over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            status_q <= OKAY;
        end else if (state_q == ACCESS) begin
            if (i_access_ready) begin
                rdata_q  <= i_read_data;
                status_q <= i_status;
            end else if (timeout_hit) begin
                rdata_q  <= '0;
                status_q <= TIMEOUT;
            end
        end
    end

    assign o_access_valid = (state_q == ACCESS);
    assign o_access_write = write_q;
    assign o_address      = addr_q;
    assign o_write_data   = wdata_q;
    assign o_write_mask   = mask_q;
    assign o_ack          = (state_q == RESPOND) ? {grant_q, ~grant_q} : 2'b00;
    assign o_read_data    = (state_q == RESPOND) ? rdata_q : '0;
    assign o_status       = (state_q == RESPOND) ? status_q : 2'b00;
endmodule
